reg_file_mp: RTL and testbench

Parametrised multi-port register file for the processor datapath: the successor to the fixed 16×32 three-read/one-write file. It provides N registered read ports, separate ALU and DMEM-load write ports, and a PC register at the top index with write priority. A per-register busy scoreboard lets the controller stall on loads that are still outstanding. It sits between instruction decode (read addresses), the ALU/DMEM result muxes (write ports) and the PC incrementer.

---
 rtl/reg_file_mp_pkg.sv | 19 +
 rtl/reg_file_mp_if.sv | 35 +++
 rtl/reg_file_mp_reg_scoreboard.sv | 34 +++
 rtl/reg_file_mp.sv | 103 ++++++++++
 tb/tb_reg_file_mp.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults, datapath typedefs and packed-port slicing helper for the
// multi-port register file.
package reg_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_PC_W   = 16;
  localparam int DEF_N_RD   = 4;
  localparam int DEF_PC_IDX = 2**DEF_ADDR_W - 1;

  typedef logic [DEF_DATA_W-1:0] reg_t;
  typedef logic [DEF_PC_W-1:0]   pc_t;

  // Base bit of port k inside a packed bus whose ports are w bits wide.
  function automatic int port_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Datapath-facing bundle of the register file: read ports, both write ports,
// load claim, PC and hazard flag.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 16,
  parameter int N_RD   = 4
);
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_busy;
  logic                   wa_en;
  logic [ADDR_W-1:0]      wa_addr;
  logic [DATA_W-1:0]      wa_data;
  logic                   wl_en;
  logic [ADDR_W-1:0]      wl_addr;
  logic [DATA_W-1:0]      wl_data;
  logic                   claim_en;
  logic [ADDR_W-1:0]      claim_addr;
  logic [PC_W-1:0]        pc_next;
  logic [PC_W-1:0]        pc_out;
  logic                   wr_hazard;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data,
           claim_en, claim_addr, pc_next,
    input  rd_data, rd_busy, pc_out, wr_hazard
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wl_en, wl_addr, wl_data,
           claim_en, claim_addr, pc_next,
    output rd_data, rd_busy, pc_out, wr_hazard
  );
endinterface

// File: rtl/reg_file_mp_reg_scoreboard.sv
// Per-register busy bits for outstanding loads; exposes both the current and
// the post-update vector so reads can see this cycle's claims and clears.
module reg_scoreboard #(
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 2**ADDR_W - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 claim_en,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic [2**ADDR_W-1:0] busy_nxt
);
  localparam int DEPTH = 2**ADDR_W;

  // A claim beats a same-cycle clear: the new load is still outstanding.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != PC_IDX && claim_en && claim_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
      else if (clr_en && clr_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, ALU/load write arbitration, PC register
// at PC_IDX and registered write-before-read outputs.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int N_RD   = DEF_N_RD,
  parameter int PC_IDX = 2**ADDR_W - 1
) (
  input logic          CLOCK_50,
  input logic          RESET,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]      regs     [DEPTH];
  logic [DATA_W-1:0]      regs_nxt [DEPTH];
  logic [PC_W-1:0]        pc_nxt;
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_nxt;
  logic                   hazard_nxt;
  logic [N_RD*DATA_W-1:0] rd_data_nxt;
  logic [N_RD-1:0]        rd_busy_nxt;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .claim_en   (bus.claim_en),
    .claim_addr (bus.claim_addr),
    .clr_en     (bus.wl_en),
    .clr_addr   (bus.wl_addr),
    .busy       (busy),
    .busy_nxt   (busy_nxt)
  );

  // ALU write wins over the load return: it belongs to the younger instruction.
  always_comb begin
    regs_nxt = regs;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != PC_IDX) begin
        if (bus.wa_en && bus.wa_addr == ADDR_W'(i))
          regs_nxt[i] = bus.wa_data;
        else if (bus.wl_en && bus.wl_addr == ADDR_W'(i))
          regs_nxt[i] = bus.wl_data;
      end
    end
  end

  always_comb begin
    pc_nxt = bus.pc_next;
    if (bus.wa_en && bus.wa_addr == ADDR_W'(PC_IDX))
      pc_nxt = bus.wa_data[PC_W-1:0];
    else if (bus.wl_en && bus.wl_addr == ADDR_W'(PC_IDX))
      pc_nxt = bus.wl_data[PC_W-1:0];
  end

  // Hazard uses the pre-update busy state of the ALU target.
  assign hazard_nxt = bus.wa_en & busy[bus.wa_addr];

  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (bus.rd_addr[port_slice(k, ADDR_W) +: ADDR_W] == ADDR_W'(PC_IDX))
        rd_data_nxt[port_slice(k, DATA_W) +: DATA_W] = DATA_W'(pc_nxt);
      else
        rd_data_nxt[port_slice(k, DATA_W) +: DATA_W] =
          regs_nxt[bus.rd_addr[port_slice(k, ADDR_W) +: ADDR_W]];
      rd_busy_nxt[k] = busy_nxt[bus.rd_addr[port_slice(k, ADDR_W) +: ADDR_W]];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == PC_IDX) regs[i] <= DATA_W'(pc_nxt);
        else             regs[i] <= regs_nxt[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      bus.rd_data   <= '0;
      bus.rd_busy   <= '0;
      bus.pc_out    <= '0;
      bus.wr_hazard <= 1'b0;
    end else begin
      bus.rd_data   <= rd_data_nxt;
      bus.rd_busy   <= rd_busy_nxt;
      bus.pc_out    <= pc_nxt;
      bus.wr_hazard <= hazard_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed plus randomized checks of reg_file_mp against an array-based
// reference model of the register file, PC and load scoreboard.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = 16;
  localparam int NR = 4;
  localparam int D  = 16;
  localparam int PCI = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_t       m_regs [D];
  logic       m_busy [D];
  pc_t        m_pc;
  reg_t       e_rd   [NR];
  logic       e_busy [NR];
  pc_t        e_pc;
  logic       e_haz;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .N_RD(NR)) bus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .N_RD(NR), .PC_IDX(PCI)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_rd(input int k);
    return bus.rd_data[k*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_pc = '0;
    for (int k = 0; k < NR; k++) begin
      e_rd[k] = '0;
      e_busy[k] = 1'b0;
    end
    e_pc = '0;
    e_haz = 1'b0;
  endtask

  // Apply one edge of architectural behaviour: later assignments override
  // earlier ones, so ordering expresses priority.
  task automatic model_edge();
    int a;
    e_haz = bus.wa_en && m_busy[bus.wa_addr];
    m_pc = bus.pc_next;
    if (bus.wl_en) begin
      if (int'(bus.wl_addr) == PCI) m_pc = bus.wl_data[PW-1:0];
      else m_regs[bus.wl_addr] = bus.wl_data;
      m_busy[bus.wl_addr] = 1'b0;
    end
    if (bus.wa_en) begin
      if (int'(bus.wa_addr) == PCI) m_pc = bus.wa_data[PW-1:0];
      else m_regs[bus.wa_addr] = bus.wa_data;
    end
    if (bus.claim_en && int'(bus.claim_addr) != PCI) m_busy[bus.claim_addr] = 1'b1;
    m_regs[PCI] = {16'h0, m_pc};
    e_pc = m_pc;
    for (int k = 0; k < NR; k++) begin
      a = int'(bus.rd_addr[k*AW +: AW]);
      e_rd[k] = m_regs[a];
      e_busy[k] = m_busy[a];
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s rd_data%0d", tag, k), dut_rd(k), e_rd[k]);
      check($sformatf("%s rd_busy%0d", tag, k), 32'(bus.rd_busy[k]), 32'(e_busy[k]));
    end
    check({tag, " pc_out"}, 32'(bus.pc_out), 32'(e_pc));
    check({tag, " wr_hazard"}, 32'(bus.wr_hazard), 32'(e_haz));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.wa_en = 1'b0;
    bus.wl_en = 1'b0;
    bus.claim_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    bus.rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();
    bus.wa_addr = '0; bus.wa_data = '0;
    bus.wl_addr = '0; bus.wl_data = '0;
    bus.claim_addr = '0;
    bus.pc_next = '0;
    set_rd(0, 1, 2, 3);
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    bus.pc_next = 16'h0004;
    step("idle");
    check("idle pc", 32'(bus.pc_out), 32'h0004);

    bus.wa_en = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 32'hDEADBEEF;
    set_rd(3, 0, 1, 2);
    step("bypass");
    check("bypass rd0", dut_rd(0), 32'hDEADBEEF);

    idle();
    bus.claim_en = 1'b1; bus.claim_addr = 4'd5;
    set_rd(5, 3, 5, 0);
    step("claim r5");
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 4'd5; bus.wa_data = 32'h11;
    bus.wl_en = 1'b1; bus.wl_addr = 4'd5; bus.wl_data = 32'h22;
    step("wa/wl r5");
    check("prio r5", dut_rd(0), 32'h11);
    check("prio busy5", 32'(bus.rd_busy[0]), 32'h0);

    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 32'h00000100;
    bus.pc_next = 16'h0008;
    set_rd(15, 5, 3, 15);
    step("pc write");
    check("pc override", 32'(bus.pc_out), 32'h0100);
    idle();
    bus.pc_next = 16'h0104;
    step("pc next");
    check("pc resume", 32'(bus.pc_out), 32'h0104);

    set_rd(7, 7, 0, 15);
    bus.claim_en = 1'b1; bus.claim_addr = 4'd7;
    step("claim r7");
    check("busy r7", 32'(bus.rd_busy[0]), 32'h1);
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 4'd7; bus.wa_data = 32'h77;
    step("hazard r7");
    check("hazard pulse", 32'(bus.wr_hazard), 32'h1);
    idle();
    bus.wl_en = 1'b1; bus.wl_addr = 4'd7; bus.wl_data = 32'h55;
    bus.claim_en = 1'b1; bus.claim_addr = 4'd7;
    step("wl+claim r7");
    check("hazard single", 32'(bus.wr_hazard), 32'h0);
    check("r7 data", dut_rd(0), 32'h55);
    check("r7 still busy", 32'(bus.rd_busy[1]), 32'h1);
    idle();
    bus.wl_en = 1'b1; bus.wl_addr = 4'd7; bus.wl_data = 32'h56;
    step("wl r7");
    check("r7 cleared", 32'(bus.rd_busy[0]), 32'h0);

    idle();
    bus.claim_en = 1'b1; bus.claim_addr = 4'd15;
    step("claim pc");
    check("pc never busy", 32'(bus.rd_busy[3]), 32'h0);

    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 4'd1; bus.wa_data = 32'hAAAA0001;
    bus.wl_en = 1'b1; bus.wl_addr = 4'd2; bus.wl_data = 32'hBBBB0002;
    set_rd(1, 2, 1, 2);
    step("w r1 r2");
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async reset");
    @(negedge clk);
    rst = 1'b0;
    bus.pc_next = 16'h0200;
    step("post reset");
    check("post reset r1", dut_rd(0), 32'h0);
    check("post reset pc", 32'(bus.pc_out), 32'h0200);

    for (int n = 0; n < 400; n++) begin
      bus.wa_en      = ($urandom_range(0, 2) != 0);
      bus.wa_addr    = AW'($urandom_range(0, 15));
      bus.wa_data    = $urandom;
      bus.wl_en      = ($urandom_range(0, 2) != 0);
      bus.wl_addr    = ($urandom_range(0, 3) == 0) ? bus.wa_addr : AW'($urandom_range(0, 15));
      bus.wl_data    = $urandom;
      bus.claim_en   = ($urandom_range(0, 1) != 0);
      bus.claim_addr = ($urandom_range(0, 3) == 0) ? bus.wl_addr : AW'($urandom_range(0, 15));
      bus.pc_next    = PW'($urandom);
      bus.rd_addr    = (NR*AW)'($urandom);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
